// File: rtl/reqrsp_to_mem.sv
// -----------------------------------------------------------------------------
// reqrsp_to_mem
//
// Bridges a reqrsp request/response port onto a simple request/grant memory
// port with in-order, variable-latency read responses.
//
// Each q handshake is exactly one memory transfer (mem_req_o && mem_gnt_i).
// Every memory response is either handed straight to the p channel in the cycle
// it arrives or parked in a small response FIFO. An outstanding-request counter
// limits the number of transfers in flight to BufDepth. This limit is the credit
// scheme that guarantees the FIFO never overflows.
//
// Ports
//   clk_i          single clock, all state on the rising edge
//   rst_i          synchronous, active-high reset
//   reqrsp_req_i   upstream request (q channel, q_valid, p_ready)
//   reqrsp_rsp_o   upstream response (p channel, p_valid, q_ready)
//   mem_req_o      memory request valid
//   mem_gnt_i      memory grant
//   mem_addr_o     memory address
//   mem_we_o       memory write enable
//   mem_wdata_o    memory write data
//   mem_strb_o     memory byte strobe (all-zero on reads)
//   mem_rvalid_i   memory response valid (one per grant, in order)
//   mem_rdata_i    memory response data
// -----------------------------------------------------------------------------

// Default reqrsp channel types. They match the default 32-bit address and data
// widths, so the module elaborates and lints as a standalone top.
package reqrsp_to_mem_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        amo_op_e     amo;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
        logic        user;
    } q_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } p_chan_t;

    typedef struct packed {
        q_chan_t q;
        logic    q_valid;
        logic    p_ready;
    } req_t;

    typedef struct packed {
        p_chan_t p;
        logic    p_valid;
        logic    q_ready;
    } rsp_t;

endpackage

// -----------------------------------------------------------------------------
// reqrsp_to_mem_chk
//
// Protocol and invariant checks for reqrsp_to_mem. This module holds no design
// state.
//
// Ports
//   clk_i, rst_i      clock and synchronous reset of the checked block
//   q_valid_i         upstream request valid
//   amo_none_i        request carries no atomic operation
//   stray_rsp_i       memory response arrived with nothing in flight
//   full_push_i       push into a full FIFO without a simultaneous pop
//   cnt_i             outstanding counter value
// -----------------------------------------------------------------------------
module reqrsp_to_mem_chk #(
    parameter int unsigned CntWidth = 2,
    parameter int unsigned BufDepth = 2
) (
    input logic                clk_i,
    input logic                rst_i,
    input logic                q_valid_i,
    input logic                amo_none_i,
    input logic                stray_rsp_i,
    input logic                full_push_i,
    input logic [CntWidth-1:0] cnt_i
);

    localparam logic [CntWidth-1:0] DepthC = CntWidth'(BufDepth);

    // Atomic operations are not supported by a plain memory port.
    a_no_amo : assert property (@(posedge clk_i) disable iff (rst_i)
        q_valid_i |-> amo_none_i)
        else $error("reqrsp_to_mem: atomic operation requested on plain memory port");

    // The credit scheme must never let the response FIFO overflow.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !full_push_i)
        else $error("reqrsp_to_mem: response pushed into full buffer");

    // The outstanding counter is bounded by the buffer depth.
    a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_i <= DepthC)
        else $error("reqrsp_to_mem: outstanding count above buffer depth");

    // Stray responses are dropped. They are legal only as late arrivals
    // after a reset, so they are reported as a warning.
    a_no_stray : assert property (@(posedge clk_i) disable iff (rst_i)
        !stray_rsp_i)
        else $warning("reqrsp_to_mem: memory response with nothing in flight dropped");

endmodule

// -----------------------------------------------------------------------------
// reqrsp_to_mem (top)
// -----------------------------------------------------------------------------
module reqrsp_to_mem #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BufDepth  = 2,
    parameter type         req_t     = reqrsp_to_mem_pkg::req_t,
    parameter type         rsp_t     = reqrsp_to_mem_pkg::rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  req_t                   reqrsp_req_i,
    output rsp_t                   reqrsp_rsp_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_strb_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned CntWidth = $clog2(BufDepth + 1);
    localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam logic [CntWidth-1:0] DepthC   = CntWidth'(BufDepth);
    localparam logic [PtrWidth-1:0] LastPtrC = PtrWidth'(BufDepth - 1);

    // Advance a FIFO pointer, wrapping at the last entry (depth need not be 2^n).
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        logic [PtrWidth-1:0] nxt;
        if (ptr == LastPtrC) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrWidth'(1);
        end
        return nxt;
    endfunction

    // Requests accepted on q but not yet accepted on p.
    logic [CntWidth-1:0]  cnt_r;
    logic [CntWidth-1:0]  cnt_nxt_s;
    // Requests granted whose memory response has not yet arrived.
    logic [CntWidth-1:0]  inflight_r;
    logic [CntWidth-1:0]  inflight_nxt_s;
    // Response FIFO occupancy and pointers.
    logic [CntWidth-1:0]  occ_r;
    logic [CntWidth-1:0]  occ_nxt_s;
    logic [PtrWidth-1:0]  rd_ptr_r;
    logic [PtrWidth-1:0]  wr_ptr_r;
    logic [DataWidth-1:0] buf_r [BufDepth];

    logic                 issue_ok_s;
    logic                 q_ready_s;
    logic                 q_hs_s;
    logic                 fifo_empty_s;
    logic                 rsp_acc_s;
    logic                 stray_rsp_s;
    logic                 p_valid_s;
    logic [DataWidth-1:0] p_data_s;
    logic                 p_hs_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_push_s;
    logic                 amo_none_s;
    logic                 unused_s;

    // Issue gate: a free credit exists and the block is out of reset.
    always_comb begin
        issue_ok_s = (!rst_i) && (cnt_r < DepthC);
    end

    // Request path: q handshake and memory transfer are the same event, and
    // the memory port is driven straight from the q channel.
    always_comb begin
        mem_req_o   = reqrsp_req_i.q_valid && issue_ok_s;
        q_ready_s   = mem_gnt_i && issue_ok_s;
        q_hs_s      = reqrsp_req_i.q_valid && q_ready_s;
        mem_addr_o  = reqrsp_req_i.q.addr;
        mem_we_o    = reqrsp_req_i.q.write;
        mem_wdata_o = reqrsp_req_i.q.data;
        if (reqrsp_req_i.q.write) begin
            mem_strb_o = reqrsp_req_i.q.strb;
        end else begin
            mem_strb_o = '0;
        end
    end

    // Response path. An empty FIFO is bypassed so that a response reaches p in
    // the cycle it arrives. Responses with nothing in flight (late arrivals
    // after a reset) are dropped here.
    always_comb begin
        fifo_empty_s = (occ_r == '0);
        rsp_acc_s    = mem_rvalid_i && (inflight_r != '0) && (!rst_i);
        stray_rsp_s  = mem_rvalid_i && (inflight_r == '0) && (!rst_i);
        p_valid_s    = (!rst_i) && ((!fifo_empty_s) || rsp_acc_s);
        if (fifo_empty_s) begin
            p_data_s = mem_rdata_i;
        end else begin
            p_data_s = buf_r[rd_ptr_r];
        end
        p_hs_s      = p_valid_s && reqrsp_req_i.p_ready;
        pop_s       = p_hs_s && (!fifo_empty_s);
        // A bypassed response that is accepted at once is never stored.
        push_s      = rsp_acc_s && !(fifo_empty_s && reqrsp_req_i.p_ready);
        full_push_s = push_s && (occ_r == DepthC) && (!pop_s);
    end

    // Upstream response assembly. Errors are never reported.
    always_comb begin
        reqrsp_rsp_o         = '0;
        reqrsp_rsp_o.p.data  = p_data_s;
        reqrsp_rsp_o.p.error = 1'b0;
        reqrsp_rsp_o.p_valid = p_valid_s;
        reqrsp_rsp_o.q_ready = q_ready_s;
    end

    // Next-state values of the outstanding, in-flight and occupancy counters.
    always_comb begin
        case ({q_hs_s, p_hs_s})
            2'b10:   cnt_nxt_s = cnt_r + CntWidth'(1);
            2'b01:   cnt_nxt_s = cnt_r - CntWidth'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
        case ({q_hs_s, rsp_acc_s})
            2'b10:   inflight_nxt_s = inflight_r + CntWidth'(1);
            2'b01:   inflight_nxt_s = inflight_r - CntWidth'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + CntWidth'(1);
            2'b01:   occ_nxt_s = occ_r - CntWidth'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Control state. Reset discards buffered and in-flight responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r      <= '0;
            inflight_r <= '0;
            occ_r      <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            inflight_r <= inflight_nxt_s;
            occ_r      <= occ_nxt_s;
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Response storage. This is a data-only array, and push_s is already
    // blocked during reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            buf_r[wr_ptr_r] <= mem_rdata_i;
        end
    end

    // Request size and user bits have no meaning on this memory port.
    always_comb begin
        amo_none_s = (reqrsp_req_i.q.amo == reqrsp_to_mem_pkg::AMONone);
        unused_s   = ^{reqrsp_req_i.q.size, reqrsp_req_i.q.user};
    end

    reqrsp_to_mem_chk #(
        .CntWidth (CntWidth),
        .BufDepth (BufDepth)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .q_valid_i   (reqrsp_req_i.q_valid),
        .amo_none_i  (amo_none_s),
        .stray_rsp_i (stray_rsp_s),
        .full_push_i (full_push_s),
        .cnt_i       (cnt_r)
    );

endmodule

// File: tb/tb_reqrsp_to_mem.sv
// -----------------------------------------------------------------------------
// tb_reqrsp_to_mem
//
// Directed and random test of reqrsp_to_mem with BufDepth = 2. A bench-side
// memory returns responses in order after 1-3 cycles. A transaction-level model
// keeps three integer counts: outstanding, in flight and returned-but-undelivered.
// A scoreboard queue holds the expected response data in request order.
// -----------------------------------------------------------------------------
module tb_reqrsp_to_mem;
    import reqrsp_to_mem_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    req_t        req;
    rsp_t        rsp;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;

    always #5 clk = ~clk;

    reqrsp_to_mem #(
        .AddrWidth (32),
        .DataWidth (32),
        .BufDepth  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reqrsp_req_i (req),
        .reqrsp_rsp_o (rsp),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_strb_o   (mem_strb),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } pend_t;

    pend_t       pend_q[$];   // memory responses scheduled by the bench memory
    logic [31:0] sb_q[$];     // expected p data in request order
    int          m_cnt, m_inflight, m_ret;
    int          cyc, last_due;
    int          n_vec, n_err;
    bit          last_qhs;
    logic [31:0] last_pdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then
    // update the reference model at the rising edge.
    task automatic cycle(input bit qv, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input bit gnt, input bit pr, input logic [31:0] rsp_data,
                         input int lat);
        bit rv, rv_cnt, issue, exp_pv, hs_q, hs_p;
        int due;
        rv = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
        req.q.addr    = addr;
        req.q.write   = wr;
        req.q.amo     = AMONone;
        req.q.data    = wdata;
        req.q.strb    = strb;
        req.q.size    = 3'($urandom_range(0, 2));
        req.q.user    = 1'($urandom_range(0, 1));
        req.q_valid   = qv;
        req.p_ready   = pr;
        mem_gnt       = gnt;
        mem_rvalid    = rv;
        mem_rdata     = rv ? pend_q[0].data : 32'($urandom);

        issue  = !rst && (m_cnt < DEPTH);
        rv_cnt = !rst && rv && (m_inflight > 0);
        exp_pv = !rst && ((m_ret > 0) || rv_cnt);
        hs_q   = qv && gnt && issue;
        hs_p   = exp_pv && pr;

        @(negedge clk);
        chk("mem_req", mem_req, qv && issue);
        chk("q_ready", rsp.q_ready, gnt && issue);
        chk("p_valid", rsp.p_valid, exp_pv);
        chk("p_error", rsp.p.error, 1'b0);
        if (!rst) chk("cnt", dut.cnt_r, m_cnt);
        if (qv) begin
            chk("mem_addr", mem_addr, addr);
            chk("mem_we", mem_we, wr);
            chk("mem_wdata", mem_wdata, wdata);
            chk("mem_strb", mem_strb, wr ? strb : 4'h0);
        end
        if (hs_p && (sb_q.size() > 0)) begin
            chk("p_data", rsp.p.data, sb_q[0]);
            last_pdata = rsp.p.data;
        end

        @(posedge clk);
        #1;
        if (rst) begin
            m_cnt = 0; m_inflight = 0; m_ret = 0;
            sb_q.delete();
        end else begin
            if (hs_q) begin
                m_cnt++; m_inflight++;
                sb_q.push_back(rsp_data);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                pend_q.push_back('{rsp_data, due});
                last_due = due;
            end
            if (rv_cnt) begin m_inflight--; m_ret++; end
            if (hs_p) begin m_ret--; m_cnt--; void'(sb_q.pop_front()); end
        end
        if (rv) void'(pend_q.pop_front());
        last_qhs = hs_q;
        cyc++;
    endtask

    task automatic idle(input bit pr);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, pr, 32'h0, 1);
    endtask

    initial begin
        bit          have;
        bit          w;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          done, nhs;

        n_vec = 0; n_err = 0; cyc = 0; last_due = -1;
        m_cnt = 0; m_inflight = 0; m_ret = 0;
        rst = 1'b1;
        req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(posedge clk);
        #1;

        // Reset: requests are blocked even with valid and grant present.
        repeat (3) cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 1);
        rst = 1'b0;

        // Single read with fall-through response.
        cycle(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1, 1'b1, 32'hDEADBEEF, 1);
        idle(1'b1);
        chk("t029_data", last_pdata, 32'hDEADBEEF);
        chk("t029_cnt", dut.cnt_r, 0);

        // Write: strobe and data pass through, one response follows.
        cycle(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b1, 32'h1234_5678, 1);
        idle(1'b1);
        idle(1'b1);
        chk("t030_cnt", dut.cnt_r, 0);

        // Back-pressure: two reads fill the credits, the third waits.
        cycle(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1111_0001, 1);
        cycle(1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1111_0002, 1);
        repeat (3) begin
            cycle(1'b1, 1'b0, 32'h208, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1111_0003, 1);
            chk("t031_blocked", last_qhs, 1'b0);
        end
        last_qhs = 1'b0;
        for (int k = 0; k < 8 && !last_qhs; k++)
            cycle(1'b1, 1'b0, 32'h208, 32'h0, 4'h0, 1'b1, 1'b1, 32'h1111_0003, 1);
        chk("t031_third_granted", last_qhs, 1'b1);
        repeat (4) idle(1'b1);

        // Streaming: one request per cycle.
        nhs = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'h0, 4'h0, 1'b1, 1'b1, 32'($urandom), 1);
            if (last_qhs) nhs++;
        end
        chk("t032_handshakes", nhs, 16);
        repeat (3) idle(1'b1);

        // Random traffic.
        have = 1'b0; done = 0; w = 1'b0; a = '0; d = '0; s = '0;
        for (int b = 0; b < 20000 && done < 1000; b++) begin
            if (!have && ($urandom_range(0, 3) != 0)) begin
                have = 1'b1;
                w = 1'($urandom_range(0, 1));
                a = $urandom & 32'hFFFF_FFFC;
                d = $urandom;
                s = 4'($urandom_range(0, 15));
            end
            cycle(have, w, a, d, s, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  32'($urandom), $urandom_range(1, 3));
            if (last_qhs) begin have = 1'b0; done++; end
        end
        chk("t033_done", done, 1000);
        for (int k = 0; k < 50 && (sb_q.size() > 0 || pend_q.size() > 0); k++) idle(1'b1);

        // Reset with one response buffered and one in flight.
        cycle(1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1'b1, 1'b0, 32'hAAAA_0001, 1);
        cycle(1'b1, 1'b0, 32'h504, 32'h0, 4'h0, 1'b1, 1'b0, 32'hAAAA_0002, 3);
        idle(1'b0);
        chk("t034_pre_cnt", dut.cnt_r, 2);
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
        chk("t034_cnt", dut.cnt_r, 0);
        for (int k = 0; k < 8 && pend_q.size() > 0; k++) idle(1'b1);
        cycle(1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 1);
        idle(1'b1);
        chk("t034_next_data", last_pdata, 32'hCAFE_F00D);
        chk("t034_end_cnt", dut.cnt_r, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
